// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs and stage write/flush controls.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             memRead_EX;
  logic [4:0]       targetReg_EX;
  logic [4:0]       srcA_ID;
  logic [4:0]       srcB_ID;
  logic             useA_ID;
  logic             useB_ID;
  logic             branchTaken_EX;
  logic             memReq_MEM;
  logic             memReady;

  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexWrite;
  logic             idexFlush;
  logic             exmemWrite;
  logic             memwbBubble;
  logic             memFault;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output memRead_EX, targetReg_EX, srcA_ID, srcB_ID, useA_ID, useB_ID,
           branchTaken_EX, memReq_MEM, memReady,
    input  pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite,
           memwbBubble, memFault, stallCount, flushCount
  );

  modport slave (
    input  memRead_EX, targetReg_EX, srcA_ID, srcB_ID, useA_ID, useB_ID,
           branchTaken_EX, memReq_MEM, memReady,
    output pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite,
           memwbBubble, memFault, stallCount, flushCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// data-memory wait with timeout fault, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [7:0]       TIMEOUT = MEM_TIMEOUT[7:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             load_use;
  logic             mem_wait;
  logic [7:0]       wait_cnt_inc;

  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic exmem_write, memwb_bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  // X31 reads as zero, so it never carries a load result forward.
  assign load_use = hz.memRead_EX && (hz.targetReg_EX != 5'd31) &&
                    ((hz.useA_ID && (hz.srcA_ID == hz.targetReg_EX)) ||
                     (hz.useB_ID && (hz.srcB_ID == hz.targetReg_EX)));

  assign mem_wait = hz.memReq_MEM && !hz.memReady;

  // Wait count including the current cycle; RUN always starts a fresh wait.
  assign wait_cnt_inc = (state_q == ST_RUN) ? 8'd1 : wait_cnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (mem_wait) begin
          wait_cnt_d  = wait_cnt_inc;
          state_d     = (wait_cnt_inc == TIMEOUT) ? ST_FAULT : ST_WAIT;
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          // Release or abort both return to RUN; this cycle is handled normally.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (hz.branchTaken_EX) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
          end else if (load_use) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_flush   = 1'b0;
    exmem_write  = 1'b0;
    memwb_bubble = 1'b1;
    if (!reset && (state_q != ST_FAULT) && !mem_wait) begin
      memwb_bubble = 1'b0;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      if (hz.branchTaken_EX) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  assign hz.pcWrite     = pc_write;
  assign hz.ifidWrite   = ifid_write;
  assign hz.ifidFlush   = ifid_flush;
  assign hz.idexWrite   = idex_write;
  assign hz.idexFlush   = idex_flush;
  assign hz.exmemWrite  = exmem_write;
  assign hz.memwbBubble = memwb_bubble;
  assign hz.memFault    = (state_q == ST_FAULT);
  assign hz.stallCount  = stall_cnt_q;
  assign hz.flushCount  = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards and taken branches. It freezes the pipeline while data memory is busy and trips a sticky fault on memory timeout. It drives the write-enable and bubble/flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps saturating stall and flush counters for performance visibility.

Parameters:
MEM_TIMEOUT, 16, number of consecutive memory-wait cycles after which memFault trips (range 1..255).
CNT_W, 16, width of the stall and flush performance counters.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
memRead_EX  input  1  instruction in EX is a load.
targetReg_EX  input  5  destination register of the EX instruction.
srcA_ID  input  5  first source register of the ID instruction.
srcB_ID  input  5  second source register of the ID instruction.
useA_ID  input  1  ID instruction actually reads srcA_ID.
useB_ID  input  1  ID instruction actually reads srcB_ID.
branchTaken_EX  input  1  branch resolved taken in EX.
memReq_MEM  input  1  load/store access active in MEM.
memReady  input  1  data memory completes the access this cycle.
pcWrite  output  1  PC update enable.
ifidWrite  output  1  IF/ID capture enable.
ifidFlush  output  1  IF/ID loads NOP.
idexWrite  output  1  ID/EX capture enable.
idexFlush  output  1  ID/EX loads zeroed control (bubble).
exmemWrite  output  1  EX/MEM capture enable.
memwbBubble  output  1  MEM/WB captures RegWrite=0, memToReg=0.
memFault  output  1  sticky memory-timeout flag.
stallCount  output  CNT_W  saturating count of stall cycles.
flushCount  output  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset is asynchronous, active-high: state RUN, waitCnt=0, memFault=0, stallCount=0, flushCount=0.
- While reset is high, the controls are pcWrite=ifidWrite=idexWrite=exmemWrite=0, ifidFlush=idexFlush=0, memwbBubble=1.
- States are RUN, WAIT and FAULT. The control outputs are combinational from state and inputs, with no added latency.
- loadUse = memRead_EX & targetReg_EX!=31 & ((useA_ID & srcA_ID==targetReg_EX) | (useB_ID & srcB_ID==targetReg_EX)). X31 (XZR) never creates a hazard.
- memWait = memReq_MEM & ~memReady.
- Per-cycle priority in RUN/WAIT is memWait > branchTaken_EX > loadUse > normal.
- Normal: all write enables 1, flushes 0, memwbBubble 0.
- memWait: pcWrite, ifidWrite, idexWrite and exmemWrite are 0; memwbBubble=1; stallCount+1.
  - A branch or load-use that coincides with memWait is not acted on. The frozen EX instruction re-presents it after the wait ends.
- branchTaken_EX (no memWait): writes 1, ifidFlush=1, idexFlush=1, flushCount+1.
  - A simultaneous loadUse is ignored, because the ID instruction is being flushed. stallCount does not increment.
- loadUse (no memWait, no branch): pcWrite=0, ifidWrite=0, idexFlush=1, idexWrite=exmemWrite=1; stallCount+1.
  - Lasts exactly one cycle, since the load then advances to MEM.
- FSM transitions:
  - RUN to WAIT on memWait, with waitCnt set to 1.
  - WAIT stays on memWait, with waitCnt+1.
  - WAIT to RUN when memReady=1 (that cycle is handled as normal/branch/loadUse) or when memReq_MEM drops (abort); waitCnt is cleared on the transition.
  - A memWait cycle with waitCnt==MEM_TIMEOUT moves to FAULT.
- FAULT: memFault=1; all write enables 0, flushes 0, memwbBubble=1. FAULT is left only by reset. The counters hold.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Reset asserted mid-wait or mid-stall returns to RUN immediately and asynchronously.

Test Plan:
- Load-use: memRead_EX=1, targetReg_EX=5, srcA_ID=5, useA_ID=1 for 1 cycle -> pcWrite=0, ifidWrite=0, idexFlush=1 that cycle; stallCount=1. Repeating with targetReg_EX=31 gives no stall, and useA_ID=0 gives no stall.
- Branch: branchTaken_EX=1 together with the same load-use condition -> ifidFlush=1, idexFlush=1, pcWrite=1; flushCount=1, stallCount=0.
- Memory wait: memReq_MEM=1, memReady=0 for 3 cycles, then memReady=1 -> PC/IF/ID/ID-EX/EX-MEM frozen and memwbBubble=1 for 3 cycles. All enables are 1 on the 4th cycle, state returns to RUN, stallCount=3.
- Branch during wait: branchTaken_EX=1 held through 2 wait cycles -> no flush while waiting; a single flush on the release cycle; flushCount=1.
- Timeout: MEM_TIMEOUT=4, memReady held 0 -> memFault=1 after the 4th wait cycle's posedge. All enables stay 0 even after memReady=1; asserting reset clears memFault and the counters.
- Saturation: CNT_W=3, 9 load-use stalls -> stallCount=7.
